// File: rtl/sap_control_sequencer.sv
// Control sequencer for the MySAP 8-bit datapath.
// A one-hot ring counter walks T1..T6: three fetch states are shared by all
// instructions, and three execute states are decoded from the IR opcode. HLT
// parks the ring in T4 with the halted flag set until the next reset.
module sap_control_sequencer #(
    parameter logic [3:0] OP_LDA       = 4'h0,
    parameter logic [3:0] OP_ADD       = 4'h1,
    parameter logic [3:0] OP_SUB       = 4'h2,
    parameter logic [3:0] OP_OUT       = 4'he,
    parameter logic [3:0] OP_HLT       = 4'hf,
    parameter bit         EARLY_RETURN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debug,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       halted,
    output logic       pc_increment,
    output logic       pc_enable_out,
    output logic       mar_load,
    output logic       ram_enable_out,
    output logic       ir_load,
    output logic       ir_enable_out,
    output logic       a_load,
    output logic       a_enable_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_enable_out,
    output logic       out_load
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state_reg;
    t_state_e state_next;
    logic     halted_reg;
    logic     halted_next;

    // The debug trace only exists in simulation models; the hardware ignores it.
    logic unused_debug;
    assign unused_debug = debug;

    // Opcode classes; anything unrecognised is treated as a NOP.
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic is_nop;

    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

    assign t_state = state_reg;
    assign halted  = halted_reg;

    // Ring counter and halt flag; reset always returns to T1, even from HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= T1;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= halted_next;
        end
    end

    // Next-state: advance the ring, honour early return, and freeze on HLT.
    // The opcode is only looked at in T4/T5, so IR changes during fetch are harmless.
    always_comb begin
        state_next  = state_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            case (state_reg)
                T1: state_next = T2;
                T2: state_next = T3;
                T3: state_next = T4;
                T4: begin
                    if (is_hlt) begin
                        halted_next = 1'b1;
                        state_next  = T4;
                    end else if (EARLY_RETURN && (is_out || is_nop)) begin
                        state_next = T1;
                    end else begin
                        state_next = T5;
                    end
                end
                T5: begin
                    if (EARLY_RETURN && is_lda) begin
                        state_next = T1;
                    end else begin
                        state_next = T6;
                    end
                end
                T6:      state_next = T1;
                default: state_next = T1;
            endcase
        end
    end

    // Control decode from the registered state; everything is held low during
    // reset and while halted. Each state enables at most one bus driver.
    always_comb begin
        pc_increment   = 1'b0;
        pc_enable_out  = 1'b0;
        mar_load       = 1'b0;
        ram_enable_out = 1'b0;
        ir_load        = 1'b0;
        ir_enable_out  = 1'b0;
        a_load         = 1'b0;
        a_enable_out   = 1'b0;
        b_load         = 1'b0;
        alu_sub        = 1'b0;
        alu_enable_out = 1'b0;
        out_load       = 1'b0;
        if (!reset && !halted_reg) begin
            case (state_reg)
                T1: begin
                    pc_enable_out = 1'b1;
                    mar_load      = 1'b1;
                end
                T2: pc_increment = 1'b1;
                T3: begin
                    ram_enable_out = 1'b1;
                    ir_load        = 1'b1;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        ir_enable_out = 1'b1;
                        mar_load      = 1'b1;
                    end else if (is_out) begin
                        a_enable_out = 1'b1;
                        out_load     = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        ram_enable_out = 1'b1;
                        a_load         = 1'b1;
                    end else if (is_add || is_sub) begin
                        ram_enable_out = 1'b1;
                        b_load         = 1'b1;
                        alu_sub        = is_sub;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        alu_enable_out = 1'b1;
                        a_load         = 1'b1;
                        alu_sub        = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer. The stimulus process drives one
// cycle at a time and queues the hand-computed outputs for that cycle; a monitor
// pops one entry at each falling edge and compares it with the selected instance.
// Instance 0 uses EARLY_RETURN=0, instance 1 uses EARLY_RETURN=1.
module tb_sap_control_sequencer;

    // Control vector bit positions (MSB first):
    // pc_increment, pc_enable_out, mar_load, ram_enable_out, ir_load, ir_enable_out,
    // a_load, a_enable_out, b_load, alu_sub, alu_enable_out, out_load
    localparam logic [11:0] PCI  = 12'h800;
    localparam logic [11:0] PCE  = 12'h400;
    localparam logic [11:0] MARL = 12'h200;
    localparam logic [11:0] RAME = 12'h100;
    localparam logic [11:0] IRL  = 12'h080;
    localparam logic [11:0] IRE  = 12'h040;
    localparam logic [11:0] AL   = 12'h020;
    localparam logic [11:0] AE   = 12'h010;
    localparam logic [11:0] BL   = 12'h008;
    localparam logic [11:0] SUBM = 12'h004;
    localparam logic [11:0] ALUE = 12'h002;
    localparam logic [11:0] OUTL = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    typedef struct {
        bit          sel;
        logic [5:0]  t;
        logic        h;
        logic [11:0] c;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       clk = 1'b0;
    logic       reset0, reset1;
    logic [3:0] op0, op1;

    logic [5:0]  t0, t1;
    logic        h0, h1;
    logic [11:0] c0, c1;

    always #5 clk = ~clk;

    sap_control_sequencer #(.EARLY_RETURN(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .debug(1'b0), .opcode(op0),
        .t_state(t0), .halted(h0),
        .pc_increment(c0[11]), .pc_enable_out(c0[10]), .mar_load(c0[9]),
        .ram_enable_out(c0[8]), .ir_load(c0[7]), .ir_enable_out(c0[6]),
        .a_load(c0[5]), .a_enable_out(c0[4]), .b_load(c0[3]),
        .alu_sub(c0[2]), .alu_enable_out(c0[1]), .out_load(c0[0])
    );

    sap_control_sequencer #(.EARLY_RETURN(1'b1)) dut1 (
        .clk(clk), .reset(reset1), .debug(1'b0), .opcode(op1),
        .t_state(t1), .halted(h1),
        .pc_increment(c1[11]), .pc_enable_out(c1[10]), .mar_load(c1[9]),
        .ram_enable_out(c1[8]), .ir_load(c1[7]), .ir_enable_out(c1[6]),
        .a_load(c1[5]), .a_enable_out(c1[4]), .b_load(c1[3]),
        .alu_sub(c1[2]), .alu_enable_out(c1[1]), .out_load(c1[0])
    );

    // One cycle: drive the selected instance, queue its expected outputs for
    // this cycle, then advance past the next rising edge. The idle instance
    // is held in reset.
    task automatic cyc(input bit sel, input logic rst, input logic [3:0] op,
                       input logic [5:0] et, input logic eh, input logic [11:0] ec,
                       input string nm);
        exp_t e;
        if (sel) begin
            reset1 = rst; op1 = op; reset0 = 1'b1;
        end else begin
            reset0 = rst; op0 = op; reset1 = 1'b1;
        end
        e.sel = sel; e.t = et; e.h = eh; e.c = ec; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Fetch T1..T3 with HLT on the opcode lines: it must be ignored before T4.
    task automatic fetch(input bit sel);
        cyc(sel, 1'b0, 4'hf, 6'h01, 1'b0, PCE | MARL, "fetch_t1");
        cyc(sel, 1'b0, 4'hf, 6'h02, 1'b0, PCI,        "fetch_t2");
        cyc(sel, 1'b0, 4'hf, 6'h04, 1'b0, RAME | IRL, "fetch_t3");
    endtask

    // Monitor: compare one queued expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [5:0]  at;
            logic        ah;
            logic [11:0] ac;
            e  = exp_q.pop_front();
            at = e.sel ? t1 : t0;
            ah = e.sel ? h1 : h0;
            ac = e.sel ? c1 : c0;
            n_checks++;
            if (at !== e.t) begin
                n_fail++;
                $display("FAIL %s t_state: got %b want %b (dut%0d)", e.name, at, e.t, e.sel);
            end
            n_checks++;
            if (ah !== e.h) begin
                n_fail++;
                $display("FAIL %s halted: got %b want %b (dut%0d)", e.name, ah, e.h, e.sel);
            end
            n_checks++;
            if (ac !== e.c) begin
                n_fail++;
                $display("FAIL %s controls: got %b want %b (dut%0d)", e.name, ac, e.c, e.sel);
            end
            n_checks++;
            if ($countones({ac[10], ac[8], ac[6], ac[4], ac[1]}) > 1) begin
                n_fail++;
                $display("FAIL %s bus_drivers: got %b want at most one set (dut%0d)",
                         e.name, {ac[10], ac[8], ac[6], ac[4], ac[1]}, e.sel);
            end
            $display("cycle %s dut%0d t_state=%b halted=%b ctrl=%b", e.name, e.sel, at, ah, ac);
        end
    end

    initial begin
        reset0 = 1'b1; reset1 = 1'b1; op0 = 4'h0; op1 = 4'h0;
        @(posedge clk);
        #1;

        // Reset state (reset just released, now in T1)
        cyc(0, 1'b0, 4'h0, 6'h01, 1'b0, PCE | MARL, "reset_t1");
        // LDA
        cyc(0, 1'b0, 4'h0, 6'h02, 1'b0, PCI,         "lda_t2");
        cyc(0, 1'b0, 4'h0, 6'h04, 1'b0, RAME | IRL,  "lda_t3");
        cyc(0, 1'b0, 4'h0, 6'h08, 1'b0, IRE | MARL,  "lda_t4");
        cyc(0, 1'b0, 4'h0, 6'h10, 1'b0, RAME | AL,   "lda_t5");
        cyc(0, 1'b0, 4'h0, 6'h20, 1'b0, NONE,        "lda_t6");
        // SUB
        fetch(0);
        cyc(0, 1'b0, 4'h2, 6'h08, 1'b0, IRE | MARL,        "sub_t4");
        cyc(0, 1'b0, 4'h2, 6'h10, 1'b0, RAME | BL | SUBM,  "sub_t5");
        cyc(0, 1'b0, 4'h2, 6'h20, 1'b0, ALUE | AL | SUBM,  "sub_t6");
        // ADD
        fetch(0);
        cyc(0, 1'b0, 4'h1, 6'h08, 1'b0, IRE | MARL, "add_t4");
        cyc(0, 1'b0, 4'h1, 6'h10, 1'b0, RAME | BL,  "add_t5");
        cyc(0, 1'b0, 4'h1, 6'h20, 1'b0, ALUE | AL,  "add_t6");
        // OUT without early return
        fetch(0);
        cyc(0, 1'b0, 4'he, 6'h08, 1'b0, AE | OUTL, "out_t4");
        cyc(0, 1'b0, 4'he, 6'h10, 1'b0, NONE,      "out_t5");
        cyc(0, 1'b0, 4'he, 6'h20, 1'b0, NONE,      "out_t6");
        // Unassigned opcode is a NOP
        fetch(0);
        cyc(0, 1'b0, 4'h5, 6'h08, 1'b0, NONE, "nop_t4");
        cyc(0, 1'b0, 4'h5, 6'h10, 1'b0, NONE, "nop_t5");
        cyc(0, 1'b0, 4'h5, 6'h20, 1'b0, NONE, "nop_t6");
        // ADD with reset asserted during T5: controls forced low, back to T1
        fetch(0);
        cyc(0, 1'b0, 4'h1, 6'h08, 1'b0, IRE | MARL, "addrst_t4");
        cyc(0, 1'b1, 4'h1, 6'h10, 1'b0, NONE,       "addrst_t5_reset");
        cyc(0, 1'b0, 4'h1, 6'h01, 1'b0, PCE | MARL, "addrst_after");
        // HLT: halts at the T4 edge, freezes for 20 cycles, leaves only on reset
        cyc(0, 1'b0, 4'hf, 6'h02, 1'b0, PCI,        "hlt_t2");
        cyc(0, 1'b0, 4'hf, 6'h04, 1'b0, RAME | IRL, "hlt_t3");
        cyc(0, 1'b0, 4'hf, 6'h08, 1'b0, NONE,       "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1'b0, 4'(i), 6'h08, 1'b1, NONE, "hlt_hold");
        end
        cyc(0, 1'b1, 4'hf, 6'h08, 1'b1, NONE,       "hlt_reset");
        cyc(0, 1'b0, 4'h0, 6'h01, 1'b0, PCE | MARL, "hlt_after_reset");

        // EARLY_RETURN=1 instance (held in reset until now, so it sits in T1)
        fetch(1);
        cyc(1, 1'b0, 4'he, 6'h08, 1'b0, AE | OUTL, "er_out_t4");
        fetch(1);
        cyc(1, 1'b0, 4'h0, 6'h08, 1'b0, IRE | MARL, "er_lda_t4");
        cyc(1, 1'b0, 4'h0, 6'h10, 1'b0, RAME | AL,  "er_lda_t5");
        fetch(1);
        cyc(1, 1'b0, 4'h5, 6'h08, 1'b0, NONE, "er_nop_t4");
        fetch(1);
        cyc(1, 1'b0, 4'h1, 6'h08, 1'b0, IRE | MARL, "er_add_t4");
        cyc(1, 1'b0, 4'h1, 6'h10, 1'b0, RAME | BL,  "er_add_t5");
        cyc(1, 1'b0, 4'h1, 6'h20, 1'b0, ALUE | AL,  "er_add_t6");
        cyc(1, 1'b0, 4'h0, 6'h01, 1'b0, PCE | MARL, "er_add_next_t1");

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
